// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-address and forwarding types, hazard FSM states,
// pipeline-register layouts and the hazard control bundle.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegAw = 5;
  localparam int unsigned Xlen  = 32;

  typedef logic [RegAw-1:0] reg_addr_t;
  typedef logic [Xlen-1:0]  word_t;

  // EX operand source select
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FwdRegFile = 2'b00;
  localparam fwd_sel_t FwdWb      = 2'b01;
  localparam fwd_sel_t FwdMem     = 2'b10;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } hz_state_e;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } if_id_t;

  typedef struct packed {
    word_t     pc;
    word_t     rd1;
    word_t     rd2;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_to_reg;
  } id_ex_t;

  typedef struct packed {
    word_t     alu_out;
    word_t     write_data;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_req;
  } ex_mem_t;

  typedef struct packed {
    word_t     result;
    reg_addr_t rd;
    logic      reg_write;
  } mem_wb_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } hz_ctrl_t;

  // x0 is hard-wired to zero, so it never produces a dependency.
  function automatic logic reg_hit(reg_addr_t producer, reg_addr_t consumer);
    return (producer != '0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Per-operand forwarding select; MEM result takes priority over the older WB result.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic      i_reg_write_m,
  input  reg_addr_t i_a3_m,
  input  logic      i_reg_write_w,
  input  reg_addr_t i_a3_w,
  input  reg_addr_t i_rs_e,
  output fwd_sel_t  o_fwd
);

  always_comb begin
    o_fwd = FwdRegFile;
    if (i_reg_write_m && reg_hit(i_a3_m, i_rs_e)) begin
      o_fwd = FwdMem;
    end else if (i_reg_write_w && reg_hit(i_a3_w, i_rs_e)) begin
      o_fwd = FwdWb;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush, memory-wait
// stall FSM with sticky timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RD1AddrD,
  input  logic [4:0]       RD2AddrD,
  input  logic [4:0]       RD1AddrE,
  input  logic [4:0]       RD2AddrE,
  input  logic [4:0]       A3E,
  input  logic [4:0]       A3M,
  input  logic [4:0]       A3W,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             PerfClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int unsigned    WaitW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  hz_state_e        r_state, w_state_next;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_next;
  logic             r_timeout, w_timeout_next;
  logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_next;

  logic     w_mem_stall, w_branch_flush, w_load_use;
  fwd_sel_t w_fwd_a, w_fwd_b;
  hz_ctrl_t w_ctrl;

  fwd_unit u_fwd_a (
    .i_reg_write_m (RegWriteM),
    .i_a3_m        (A3M),
    .i_reg_write_w (RegWriteW),
    .i_a3_w        (A3W),
    .i_rs_e        (RD1AddrE),
    .o_fwd         (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_reg_write_m (RegWriteM),
    .i_a3_m        (A3M),
    .i_reg_write_w (RegWriteW),
    .i_a3_w        (A3W),
    .i_rs_e        (RD2AddrE),
    .o_fwd         (w_fwd_b)
  );

  // The stall is raised in the same cycle the miss is seen, not one cycle later.
  always_comb begin
    w_state_next = r_state;
    w_mem_stall  = 1'b0;
    case (r_state)
      StRun: begin
        if (MemReqM && !MemReadyM) begin
          w_mem_stall  = 1'b1;
          w_state_next = StMemWait;
        end
      end
      StMemWait: begin
        if (MemReadyM) begin
          w_state_next = StRun;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
    endcase
  end

  // A frozen pipeline ignores branch and load-use; they are re-evaluated on release.
  assign w_branch_flush = !w_mem_stall && BranchTakenE;
  assign w_load_use     = !w_mem_stall && !BranchTakenE && MemtoRegE &&
                          (reg_hit(A3E, RD1AddrD) || reg_hit(A3E, RD2AddrD));

  always_comb begin
    w_ctrl = '0;
    if (rst) begin
      w_ctrl.flush_d = 1'b1;
      w_ctrl.flush_e = 1'b1;
    end else begin
      w_ctrl.stall_f = w_mem_stall || w_load_use;
      w_ctrl.stall_d = w_mem_stall || w_load_use;
      w_ctrl.stall_e = w_mem_stall;
      w_ctrl.stall_m = w_mem_stall;
      w_ctrl.flush_d = w_branch_flush;
      w_ctrl.flush_e = w_branch_flush || w_load_use;
    end
  end

  assign StallF     = w_ctrl.stall_f;
  assign StallD     = w_ctrl.stall_d;
  assign StallE     = w_ctrl.stall_e;
  assign StallM     = w_ctrl.stall_m;
  assign FlushD     = w_ctrl.flush_d;
  assign FlushE     = w_ctrl.flush_e;
  assign ForwardAE  = rst ? FwdRegFile : w_fwd_a;
  assign ForwardBE  = rst ? FwdRegFile : w_fwd_b;
  assign MemTimeout = r_timeout;
  assign StallCnt   = r_stall_cnt;

  // Only cycles spent in MEM_WAIT that keep waiting advance the counter; it saturates so a
  // long hang cannot wrap it back below the threshold.
  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (w_state_next == StRun) begin
      w_wait_cnt_next = '0;
    end else if (r_state == StMemWait && r_wait_cnt != WaitMax) begin
      w_wait_cnt_next = r_wait_cnt + WaitW'(1);
    end
    w_timeout_next = r_timeout || (w_wait_cnt_next == WaitMax);
  end

  always_comb begin
    w_stall_cnt_next = r_stall_cnt;
    if (PerfClr) begin
      w_stall_cnt_next = '0;
    end else if (w_ctrl.stall_f && r_stall_cnt != CntMax) begin
      w_stall_cnt_next = r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_wait_cnt  <= w_wait_cnt_next;
      r_timeout   <= w_timeout_next;
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW  = 4;
  localparam int unsigned MemTo = 4;
  localparam int          CntSat = (1 << CntW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      RD1AddrD, RD2AddrD, RD1AddrE, RD2AddrE, A3E, A3M, A3W;
  logic            MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, MemReqM, MemReadyM, PerfClr;
  logic            StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [CntW-1:0] StallCnt;

  pipe_hazard_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (MemTo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RD1AddrD     (RD1AddrD),
    .RD2AddrD     (RD2AddrD),
    .RD1AddrE     (RD1AddrE),
    .RD2AddrE     (RD2AddrE),
    .A3E          (A3E),
    .A3M          (A3M),
    .A3W          (A3W),
    .MemtoRegE    (MemtoRegE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .BranchTakenE (BranchTakenE),
    .MemReqM      (MemReqM),
    .MemReadyM    (MemReadyM),
    .PerfClr      (PerfClr),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .MemTimeout   (MemTimeout),
    .StallCnt     (StallCnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model state: is the memory still outstanding, how long it has hung, sticky flag, counter.
  bit m_known   = 0;
  bit m_waiting = 0;
  int m_wait    = 0;
  bit m_timeout = 0;
  int m_cnt     = 0;

  bit         e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
  logic [1:0] e_fa, e_fb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && A3M != 0 && A3M == rs) return 2'b10;
    if (RegWriteW && A3W != 0 && A3W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit mem, br, lu;
    mem = m_waiting ? !MemReadyM : (MemReqM && !MemReadyM);
    if (rst) mem = 0;
    br = !rst && !mem && BranchTakenE;
    lu = !rst && !mem && !BranchTakenE && MemtoRegE && A3E != 0 &&
         (A3E == RD1AddrD || A3E == RD2AddrD);
    e_sf = mem || lu;
    e_sd = mem || lu;
    e_se = mem;
    e_sm = mem;
    e_fd = rst || br;
    e_fe = rst || br || lu;
    e_fa = rst ? 2'b00 : fwd_ref(RD1AddrE);
    e_fb = rst ? 2'b00 : fwd_ref(RD2AddrE);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_known   = 1;
      m_waiting = 0;
      m_wait    = 0;
      m_timeout = 0;
      m_cnt     = 0;
    end else begin
      if (PerfClr) m_cnt = 0;
      else if (e_sf && m_cnt < CntSat) m_cnt++;
      if (e_se) begin
        if (m_waiting) begin
          m_wait++;
          if (m_wait >= MemTo) m_timeout = 1;
        end
        m_waiting = 1;
      end else begin
        m_waiting = 0;
        m_wait    = 0;
      end
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #2;
    model_comb();
    check("StallF", StallF, e_sf);
    check("StallD", StallD, e_sd);
    check("StallE", StallE, e_se);
    check("StallM", StallM, e_sm);
    check("FlushD", FlushD, e_fd);
    check("FlushE", FlushE, e_fe);
    check("ForwardAE", ForwardAE, e_fa);
    check("ForwardBE", ForwardBE, e_fb);
    if (m_known) begin
      check("StallCnt", StallCnt, m_cnt);
      check("MemTimeout", MemTimeout, m_timeout);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    RD1AddrD = 0; RD2AddrD = 0; RD1AddrE = 0; RD2AddrE = 0;
    A3E = 0; A3M = 0; A3W = 0;
    MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0; BranchTakenE = 0;
    MemReqM = 0; MemReadyM = 0; PerfClr = 0;
  endtask

  task automatic rand_inputs();
    RD1AddrD     = 5'($urandom_range(0, 3));
    RD2AddrD     = 5'($urandom_range(0, 3));
    RD1AddrE     = 5'($urandom_range(0, 3));
    RD2AddrE     = 5'($urandom_range(0, 3));
    A3E          = 5'($urandom_range(0, 3));
    A3M          = 5'($urandom_range(0, 3));
    A3W          = 5'($urandom_range(0, 3));
    MemtoRegE    = 1'($urandom_range(0, 1));
    RegWriteM    = 1'($urandom_range(0, 1));
    RegWriteW    = 1'($urandom_range(0, 1));
    BranchTakenE = ($urandom_range(0, 5) == 0);
    MemReqM      = ($urandom_range(0, 2) == 0);
    MemReadyM    = 1'($urandom_range(0, 1));
    PerfClr      = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    // Reset with busy inputs: outputs must hold their reset values
    rand_inputs();
    MemReqM = 1; MemReadyM = 0; BranchTakenE = 0; RegWriteM = 1; A3M = 3; RD1AddrE = 3;
    rst = 1;
    #2;
    check("rst_FlushD", FlushD, 1);
    check("rst_StallF", StallF, 0);
    check("rst_ForwardAE", ForwardAE, 0);
    cycle();
    cycle();
    rst = 0;
    idle();
    cycle();
    check("post_rst_StallCnt", StallCnt, 0);
    check("post_rst_MemTimeout", MemTimeout, 0);

    // Load-use on rs1
    A3E = 5; MemtoRegE = 1; RD1AddrD = 5;
    #2;
    check("lu_StallF", StallF, 1);
    check("lu_FlushE", FlushE, 1);
    check("lu_StallE", StallE, 0);
    cycle();
    idle();
    cycle();
    check("lu_StallCnt", StallCnt, 1);
    // Load-use on rs2, then x0 never hazards
    A3E = 9; MemtoRegE = 1; RD2AddrD = 9;
    cycle();
    A3E = 0; RD1AddrD = 0; RD2AddrD = 0;
    #2;
    check("x0_no_stall", StallF, 0);
    cycle();

    // Forwarding priority and x0
    idle();
    RegWriteM = 1; RegWriteW = 1; A3M = 7; A3W = 7; RD1AddrE = 7;
    #2;
    check("fwd_mem", ForwardAE, 2'b10);
    cycle();
    RegWriteM = 0;
    #2;
    check("fwd_wb", ForwardAE, 2'b01);
    cycle();
    A3M = 0; A3W = 0; RegWriteM = 1; RD1AddrE = 0; RD2AddrE = 0;
    #2;
    check("fwd_x0", ForwardAE, 2'b00);
    cycle();

    // Memory stall of three cycles
    idle();
    PerfClr = 1;
    cycle();
    PerfClr = 0;
    MemReqM = 1; MemReadyM = 0;
    repeat (3) cycle();
    MemReadyM = 1;
    #2;
    check("mem_release_StallF", StallF, 0);
    cycle();
    idle();
    #2;
    check("mem_run_StallM", StallM, 0);
    cycle();
    check("mem_StallCnt", StallCnt, 3);

    // Branch beats load-use; memory stall beats both
    BranchTakenE = 1; MemtoRegE = 1; A3E = 5; RD1AddrD = 5;
    #2;
    check("br_FlushD", FlushD, 1);
    check("br_StallF", StallF, 0);
    cycle();
    MemReqM = 1; MemReadyM = 0;
    cycle();
    #2;
    check("wait_br_FlushD", FlushD, 0);
    check("wait_br_FlushE", FlushE, 0);
    check("wait_br_StallF", StallF, 1);
    cycle();
    MemReadyM = 1;
    cycle();
    idle();
    cycle();

    // Timeout after the fourth MEM_WAIT cycle, then reset mid-wait
    MemReqM = 1; MemReadyM = 0;
    repeat (4) cycle();
    check("to_before", MemTimeout, 0);
    cycle();
    check("to_set", MemTimeout, 1);
    cycle();
    check("to_sticky", MemTimeout, 1);
    rst = 1;
    cycle();
    rst = 0;
    idle();
    #2;
    check("rst_wait_StallF", StallF, 0);
    check("rst_wait_MemTimeout", MemTimeout, 0);
    check("rst_wait_StallCnt", StallCnt, 0);
    cycle();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 79) == 0);
      cycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-002 Parameter MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before the timeout flag sets.
REQ-003 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 RD1AddrD, RD2AddrD  input  5 each  source register addresses of the instruction in ID.
REQ-006 RD1AddrE, RD2AddrE  input  5 each  source register addresses of the instruction in EX.
REQ-007 A3E, A3M, A3W  input  5 each  destination register addresses in EX, MEM and WB.
REQ-008 MemtoRegE  input  1  the EX instruction is a load.
REQ-009 RegWriteM, RegWriteW  input  1 each  register-write enables in MEM and WB.
REQ-010 BranchTakenE  input  1  branch/jump resolved taken in EX.
REQ-011 MemReqM, MemReadyM  input  1 each  data-memory request in MEM, and memory completion.
REQ-012 PerfClr  input  1  clears the stall counter.
REQ-013 StallF, StallD, StallE, StallM  output  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-014 FlushD, FlushE  output  1 each  load a bubble into IF/ID or ID/EX.
REQ-015 ForwardAE, ForwardBE  output  2 each  EX operand select: 00 register file, 01 WB result, 10 MEM result.
REQ-016 MemTimeout  output  1  sticky memory-timeout error flag.
REQ-017 StallCnt  output  CNT_W  count of cycles with StallF asserted.

Function
REQ-018 The FSM SHALL have exactly two states, RUN and MEM_WAIT.
REQ-019 Forwarding SHALL be combinational: ForwardAE = 10 when RegWriteM, A3M != 0 and A3M == RD1AddrE; otherwise 01 when RegWriteW, A3W != 0 and A3W == RD1AddrE; otherwise 00.
REQ-020 ForwardBE SHALL follow the same rule as ForwardAE using RD2AddrE, with MEM taking priority over WB.
REQ-021 Register address 0 SHALL never cause forwarding or a load-use stall.
REQ-022 Memory stall: in RUN, MemReqM=1 with MemReadyM=0 SHALL assert StallF, StallD, StallE and StallM combinationally in that same cycle and move the FSM to MEM_WAIT.
REQ-023 In MEM_WAIT, all four stalls SHALL stay asserted while MemReadyM=0.
REQ-024 In MEM_WAIT, MemReadyM=1 SHALL deassert all stalls in that same cycle and return the FSM to RUN.
REQ-025 While any memory stall is asserted, FlushD and FlushE SHALL be 0, and BranchTakenE and load-use detection SHALL be ignored; the EX instruction is frozen and is re-evaluated after release.
REQ-026 Branch: with no memory stall, BranchTakenE=1 SHALL assert FlushD and FlushE for exactly that cycle, with StallF=StallD=0.
REQ-027 A taken branch SHALL suppress load-use stalling in the same cycle.
REQ-028 Load-use: with no memory stall and no taken branch, MemtoRegE=1, A3E != 0 and A3E equal to RD1AddrD or RD2AddrD SHALL assert StallF, StallD and FlushE for one cycle, with StallE=StallM=0.
REQ-029 Priority SHALL be: memory stall > branch flush > load-use stall.
REQ-030 Timeout: a wait counter SHALL increment on each MEM_WAIT cycle and clear on entry to RUN.
REQ-031 MemTimeout SHALL set when the wait counter reaches MEM_TIMEOUT and hold until rst; the FSM SHALL keep waiting regardless.
REQ-032 StallCnt SHALL increment by 1 on each cycle with StallF=1, saturating at all-ones.
REQ-033 PerfClr=1 SHALL zero StallCnt on the next edge, overriding any increment in that cycle.

Reset
REQ-034 While rst=1, the block SHALL drive StallF/D/E/M=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00, and ignore all other inputs.
REQ-035 On an edge with rst=1, the FSM SHALL go to RUN and the wait counter, StallCnt and MemTimeout SHALL go to 0, including from MEM_WAIT mid-operation.

Structure
REQ-036 The forwarding encodings (00/01/10) and the FSM state encoding SHALL be defined as constants in the shared pipeline package, alongside the pipeline-register definitions.
REQ-037 The forwarding logic SHALL be one sub-module, fwd_unit, instantiated twice (A and B); everything else is flat.

Verification
REQ-038 Load-use: A3E=5, MemtoRegE=1, RD1AddrD=5 -> StallF=StallD=FlushE=1 for 1 cycle, StallCnt +1.
REQ-039 Forwarding: RegWriteM=RegWriteW=1, A3M=A3W=7, RD1AddrE=7 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01; then A3M=A3W=0 -> ForwardAE=00.
REQ-040 Memory stall: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls high for exactly 3 cycles, FSM back in RUN, StallCnt=3.
REQ-041 Conflicts: BranchTakenE=1 together with a load-use hazard -> FlushD=FlushE=1, StallF=0; the same inputs during MEM_WAIT -> flushes 0, stalls 1.
REQ-042 Timeout/reset: MEM_TIMEOUT=4, MemReadyM held 0 -> MemTimeout=1 after the 4th MEM_WAIT cycle; then rst for 1 cycle -> RUN, MemTimeout=0, StallCnt=0.
